rr_arbiter8: RTL and testbench
==============================

# rr_arbiter8

Eight-requester round-robin arbiter that shares one downstream resource among eight clients. Each cycle it selects at most one requester, drives a one-hot grant plus the 3-bit encoded index of the winner, and holds the grant while the winner keeps requesting, up to an optional hold limit. It sits between the request lines and the encoded-select input of the shared datapath. It replaces a purely combinational encoder with a fair, stateful scheduler.

## Interface
- MAX_HOLD, default 4: maximum consecutive cycles one requester keeps the grant while others wait; 0 = unlimited.
- clk  in  1  rising-edge clock, sole clock domain.
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- req  in  8  request lines, bit i = requester i, level-sensitive.
- gnt  out  8  one-hot grant, registered; all zero when no grant.
- gnt_idx  out  3  binary index of the granted requester, registered; 0 when gnt_valid=0.
- gnt_valid  out  1  high while a grant is held, registered.

## Operation
- Internal state: FSM {IDLE, GRANT}; ptr[2:0], the start of the priority search; hold_cnt, the count of cycles the current grant has been held.
- Search rule: among a candidate mask, pick the first set bit scanning ptr, ptr+1, … modulo 8. Wrap from 7 to 0 is mandatory.
- In IDLE with req==0: stay in IDLE; outputs stay zero.
- In IDLE with req!=0: grant the winner from the full req mask; go to GRANT; hold_cnt=1; ptr=winner+1 (mod 8).
- In GRANT, the winner keeps requesting, and either MAX_HOLD==0 or hold_cnt<MAX_HOLD: keep the grant; hold_cnt+1.
- In GRANT, the winner keeps requesting, hold_cnt==MAX_HOLD, and another request is pending: force rotation. The new winner comes from req with the current bit masked, searched from ptr. hold_cnt=1.
- In GRANT, the winner keeps requesting, hold_cnt==MAX_HOLD, and no other request is pending: keep the grant; hold_cnt=1. The counter restarts and does not saturate.
- In GRANT, the winner drops req: rearbitrate on the same edge from req masked with the current bit. If a winner exists, grant it with no bubble cycle. Otherwise go to IDLE and clear all outputs.
- Every new grant sets ptr=winner+1. Holding a grant does not move ptr.
- Invariants: popcount(gnt)≤1; gnt==(1<<gnt_idx) when gnt_valid=1; gnt_valid==(gnt!=0); a grant is never given to a requester whose req was low at the deciding edge.
- hold_cnt width: max(1, $clog2(MAX_HOLD+1)). Compare equal only; no overflow is possible.

## Timing
- Reset (rst_n=0 at a rising edge): gnt=0, gnt_idx=0, gnt_valid=0, FSM=IDLE, ptr=0, hold_cnt=0. Reset overrides everything, including a grant in progress. The first grant is possible on the first edge after rst_n returns high.
- Latency: req sampled at edge k produces a registered grant visible after edge k, i.e. one cycle.
- Release: when the winner deasserts req before edge k, the grant changes or clears at edge k. The downstream resource must tolerate one cycle of grant after the request drops.
- Simultaneous release and limit hit: release takes precedence; the result is identical anyway, since both rearbitrate with the current bit masked.
- New requests arriving while a grant is held cause no output change until a release or a forced rotation.
- With MAX_HOLD=N and all 8 requesting continuously, each requester gets exactly N consecutive cycles, in order i, i+1, …, wrapping.

## Structure
- Package arb_pkg holds:
  - constants N_REQ=8 and IDX_W=3;
  - a typedef for the FSM enum {IDLE, GRANT};
  - a typedef for the req/gnt vector.
- One combinational sub-module, rr_pick8, does the rotating priority search.
  - Inputs: mask[7:0], ptr[2:0].
  - Outputs: found, idx[2:0], onehot[7:0].
- rr_arbiter8 holds the FSM, ptr, hold_cnt and the output registers.

## Test plan
- Reset mid-grant: grant requester 5, then assert rst_n=0 for one edge. Required: all outputs 0 and ptr=0. Then with req=8'hFF, the first grant is gnt_idx=0.
- Single requester: req=8'h08 held 10 cycles, MAX_HOLD=4. Required: gnt=8'h08 and gnt_idx=3 from cycle 1 through cycle 10, never dropping. Drop req; outputs reach 0 one edge later.
- Full contention: MAX_HOLD=2, req=8'hFF. Required: gnt_idx sequence 0,0,1,1,…,7,7,0,0, with wrap 7→0.
- Release with no bubble: req=8'h81, grant at idx 0. Drop bit 0. Required: the next edge gives gnt_idx=7, with gnt_valid staying high.
- Wrap search: ptr=6 (after granting idx 5, then release), req=8'h03. Required: gnt_idx=0, then 1 after req[0] drops.
- Unlimited hold: MAX_HOLD=0, req=8'h11. Required: idx 0 is held 50 cycles. Drop bit 0; the grant moves to idx 4 on the next edge.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants and types for the eight-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef logic [N_REQ-1:0] req_vec_t;

endpackage : arb_pkg

// File: rtl/rr_pick8.sv
// Rotating priority search: first set bit of mask scanning ptr, ptr+1, ... mod 8.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] mask,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  // Mask rotated so that bit 0 is the requester at ptr; 3-bit add wraps 7 -> 0.
  logic [N_REQ-1:0] w_rot;
  logic [IDX_W-1:0] w_enc;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign w_rot[gi] = mask[ptr + IDX_W'(gi)];
    end
  endgenerate

  // Lowest set bit of the rotated mask, mapped back to an absolute index.
  always_comb begin
    w_enc  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_enc = IDX_W'(k);
      end
    end
    found  = |w_rot;
    idx    = found ? (ptr + w_enc) : '0;
    onehot = found ? (req_vec_t'(1) << idx) : '0;
  end

endmodule : rr_pick8

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with grant hold and optional hold limit.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

  arb_state_t       r_state, w_state_next;
  logic [IDX_W-1:0] r_ptr, w_ptr_next;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_next;
  logic [N_REQ-1:0] r_gnt, w_gnt_next;
  logic [IDX_W-1:0] r_gnt_idx, w_gnt_idx_next;
  logic             r_gnt_valid, w_gnt_valid_next;

  logic [N_REQ-1:0] w_pick_mask;
  logic             w_found;
  logic [IDX_W-1:0] w_idx;
  logic [N_REQ-1:0] w_onehot;
  logic             w_still;
  logic             w_limit;

  // While granting, the current winner is excluded from the search so a
  // release or a forced rotation both land on someone else.
  assign w_pick_mask = (r_state == GRANT) ? (req & ~r_gnt) : req;
  assign w_still     = |(req & r_gnt);
  assign w_limit     = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LIM);

  rr_pick8 u_pick (
    .mask   (w_pick_mask),
    .ptr    (r_ptr),
    .found  (w_found),
    .idx    (w_idx),
    .onehot (w_onehot)
  );

  // Next-state and next-output logic; holding never moves the pointer.
  always_comb begin
    w_state_next     = r_state;
    w_ptr_next       = r_ptr;
    w_hold_cnt_next  = r_hold_cnt;
    w_gnt_next       = r_gnt;
    w_gnt_idx_next   = r_gnt_idx;
    w_gnt_valid_next = r_gnt_valid;
    case (r_state)
      GRANT: begin
        if (w_still && !w_limit) begin
          w_hold_cnt_next = r_hold_cnt + HOLD_W'(1);
        end else if (w_still && !w_found) begin
          // Limit reached but nobody else waiting: restart the hold count.
          w_hold_cnt_next = HOLD_W'(1);
        end else if (w_found) begin
          w_state_next     = GRANT;
          w_gnt_next       = w_onehot;
          w_gnt_idx_next   = w_idx;
          w_gnt_valid_next = 1'b1;
          w_hold_cnt_next  = HOLD_W'(1);
          w_ptr_next       = w_idx + IDX_W'(1);
        end else begin
          w_state_next     = IDLE;
          w_gnt_next       = '0;
          w_gnt_idx_next   = '0;
          w_gnt_valid_next = 1'b0;
          w_hold_cnt_next  = '0;
        end
      end
      default: begin
        if (w_found) begin
          w_state_next     = GRANT;
          w_gnt_next       = w_onehot;
          w_gnt_idx_next   = w_idx;
          w_gnt_valid_next = 1'b1;
          w_hold_cnt_next  = HOLD_W'(1);
          w_ptr_next       = w_idx + IDX_W'(1);
        end else begin
          w_state_next     = IDLE;
          w_gnt_next       = '0;
          w_gnt_idx_next   = '0;
          w_gnt_valid_next = 1'b0;
          w_hold_cnt_next  = '0;
        end
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_hold_cnt  <= '0;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_ptr       <= w_ptr_next;
      r_hold_cnt  <= w_hold_cnt_next;
      r_gnt       <= w_gnt_next;
      r_gnt_idx   <= w_gnt_idx_next;
      r_gnt_valid <= w_gnt_valid_next;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;

endmodule : rr_arbiter8

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 with hold limits 4, 2 and unlimited.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req_h4 = '0, req_h2 = '0, req_h0 = '0;
  logic [7:0] gnt_h4, gnt_h2, gnt_h0;
  logic [2:0] idx_h4, idx_h2, idx_h0;
  logic       vld_h4, vld_h2, vld_h0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] req;
    logic       valid;
    logic [2:0] idx;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  rr_arbiter8 #(.MAX_HOLD(4)) u_h4 (
    .clk(clk), .rst_n(rst_n), .req(req_h4),
    .gnt(gnt_h4), .gnt_idx(idx_h4), .gnt_valid(vld_h4)
  );
  rr_arbiter8 #(.MAX_HOLD(2)) u_h2 (
    .clk(clk), .rst_n(rst_n), .req(req_h2),
    .gnt(gnt_h2), .gnt_idx(idx_h2), .gnt_valid(vld_h2)
  );
  rr_arbiter8 #(.MAX_HOLD(0)) u_h0 (
    .clk(clk), .rst_n(rst_n), .req(req_h0),
    .gnt(gnt_h0), .gnt_idx(idx_h0), .gnt_valid(vld_h0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] g, input logic [2:0] i,
                     input logic v, input logic ev, input logic [2:0] ei);
    logic [7:0] eg;
    logic [2:0] eidx;
    eg   = ev ? (8'h01 << ei) : 8'h00;
    eidx = ev ? ei : 3'd0;
    checks++;
    if (g !== eg || i !== eidx || v !== ev) begin
      errors++;
      $display("FAIL %s: got gnt=%h idx=%0d valid=%b, expected gnt=%h idx=%0d valid=%b",
               name, g, i, v, eg, eidx, ev);
    end else begin
      $display("ok   %s: gnt=%h idx=%0d valid=%b", name, g, i, v);
    end
  endtask

  task automatic add(input logic [7:0] r, input logic v, input logic [2:0] i, input int n);
    vec_t e;
    e.req = r; e.valid = v; e.idx = i;
    for (int k = 0; k < n; k++) tbl.push_back(e);
  endtask

  initial begin
    // Single requester 3 held past the limit with nobody else waiting.
    add(8'h08, 1'b1, 3'd3, 10);
    add(8'h00, 1'b0, 3'd0, 2);
    // Release with no bubble in both directions (7 -> 0, 0 -> 7).
    add(8'h81, 1'b1, 3'd7, 1);
    add(8'h01, 1'b1, 3'd0, 1);
    add(8'h81, 1'b1, 3'd0, 1);
    add(8'h80, 1'b1, 3'd7, 1);
    add(8'h00, 1'b0, 3'd0, 1);
    // Wrap search: grant 5 leaves ptr=6, then 8'h03 must wrap to 0.
    add(8'h20, 1'b1, 3'd5, 1);
    add(8'h00, 1'b0, 3'd0, 1);
    add(8'h03, 1'b1, 3'd0, 1);
    add(8'h02, 1'b1, 3'd1, 1);
    add(8'h00, 1'b0, 3'd0, 1);
    // Forced rotation after four cycles, search wraps 4..7,0,1,2.
    add(8'h0C, 1'b1, 3'd2, 4);
    add(8'h0C, 1'b1, 3'd3, 4);
    add(8'h0C, 1'b1, 3'd2, 1);
    add(8'h00, 1'b0, 3'd0, 1);
    // Late arrivals do not disturb a held grant; release goes to 0 via wrap.
    add(8'h10, 1'b1, 3'd4, 1);
    add(8'h11, 1'b1, 3'd4, 1);
    add(8'h13, 1'b1, 3'd4, 1);
    add(8'h01, 1'b1, 3'd0, 1);
    add(8'h00, 1'b0, 3'd0, 1);

    // Reset state.
    rst_n = 1'b0;
    tick();
    tick();
    chk("reset_h4", gnt_h4, idx_h4, vld_h4, 1'b0, 3'd0);
    chk("reset_h2", gnt_h2, idx_h2, vld_h2, 1'b0, 3'd0);
    chk("reset_h0", gnt_h0, idx_h0, vld_h0, 1'b0, 3'd0);
    rst_n = 1'b1;

    // Table-driven sequence on the MAX_HOLD=4 instance.
    foreach (tbl[n]) begin
      req_h4 = tbl[n].req;
      tick();
      chk($sformatf("vec%0d_req%h", n, tbl[n].req), gnt_h4, idx_h4, vld_h4,
          tbl[n].valid, tbl[n].idx);
    end

    // Reset in the middle of a grant to requester 5.
    req_h4 = 8'h20;
    tick();
    chk("pre_reset_grant5", gnt_h4, idx_h4, vld_h4, 1'b1, 3'd5);
    rst_n = 1'b0;
    tick();
    chk("mid_grant_reset", gnt_h4, idx_h4, vld_h4, 1'b0, 3'd0);
    rst_n  = 1'b1;
    req_h4 = 8'hFF;
    tick();
    chk("post_reset_ptr0", gnt_h4, idx_h4, vld_h4, 1'b1, 3'd0);
    req_h4 = 8'h00;

    // Full contention with MAX_HOLD=2: two cycles each, wrapping 7 -> 0.
    req_h2 = 8'hFF;
    for (int k = 0; k < 18; k++) begin
      tick();
      chk($sformatf("contend_%0d", k), gnt_h2, idx_h2, vld_h2, 1'b1, 3'((k / 2) % 8));
    end
    req_h2 = 8'h00;
    tick();
    chk("contend_release", gnt_h2, idx_h2, vld_h2, 1'b0, 3'd0);

    // Unlimited hold: requester 0 keeps the grant for 50 cycles.
    req_h0 = 8'h11;
    for (int k = 0; k < 50; k++) begin
      tick();
      chk($sformatf("unlim_%0d", k), gnt_h0, idx_h0, vld_h0, 1'b1, 3'd0);
    end
    req_h0 = 8'h10;
    tick();
    chk("unlim_handoff", gnt_h0, idx_h0, vld_h0, 1'b1, 3'd4);
    req_h0 = 8'h00;
    tick();
    chk("unlim_idle", gnt_h0, idx_h0, vld_h0, 1'b0, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rr_arbiter8
